hazard_sb: RTL and testbench

Parametrised pipeline hazard controller for the five-stage MIPS core. Supersedes the purely combinational hazard logic:
- generates E-stage and D-stage forwarding selects, load-use stalls and branch/jump stalls;
- tracks a multi-cycle multiply/divide unit with an internal busy counter;
- freezes the whole pipeline on instruction- or data-memory wait;
- flushes on exceptions.

Sits beside the datapath and drives every stage's stall/flush enables.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_sb_md_tracker.sv | 83 ++++++++
 rtl/hazard_sb.sv | 131 +++++++++++++
 tb/tb_hazard_sb.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // E-stage operand source selects.
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Multiply/divide occupancy tracker states.
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

    // Larger of two latencies; sizes the MD down-counter.
    function automatic int max_lat(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_sb_md_tracker.sv
// Multiply/divide unit occupancy tracker.
//
// state   | meaning
// --------+-----------------------------------------------------------
// MD_IDLE | unit free; an accepted start loads the latency counter
// MD_RUN  | unit busy; counter counts down to 1, then done pulses
//
// The counter runs independently of pipeline stalls. abort (exception)
// drops an in-flight op with no done pulse.
module md_tracker
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 34
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    input  logic abort,
    output logic busy,
    output logic done
);

    localparam int CNT_W = $clog2(max_lat(MUL_LAT, DIV_LAT) + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             done_q, done_nxt;

    // Next-state, counter and done-pulse logic; abort overrides everything.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    state_nxt = MD_RUN;
                    cnt_nxt   = is_div ? DIV_CNT : MUL_CNT;
                end
            end
            MD_RUN: begin
                if (cnt == CNT_ONE) begin
                    state_nxt = MD_IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = MD_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (abort) begin
            state_nxt = MD_IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b0;
        end
    end

    // State, counter and registered done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            done_q <= done_nxt;
        end
    end

    assign busy = (state == MD_RUN);
    assign done = done_q;

endmodule

// File: rtl/hazard_sb.sv
// Five-stage MIPS hazard controller: forwarding selects, hazard stalls,
// memory-wait freeze, exception flush and MD-unit tracking.
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 34
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic              jrD,
    input  logic              hilotoregD,
    input  logic              mdstartD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              mdstartE,
    input  logic              divE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    input  logic              imem_stall,
    input  logic              dmem_stall,
    input  logic              exc_flush,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              stallW,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              md_busy,
    output logic              md_done
);

    logic lu_stall, br_stall, brld_stall, md_stall, h_stall;
    logic mem_stall;
    logic md_start;

    // E-stage forwarding: M result wins over W; register 0 never forwards.
    always_comb begin
        forwardaE = FWD_RF;
        if (rsE != '0 && regwriteM && rsE == writeregM)
            forwardaE = FWD_M;
        else if (rsE != '0 && regwriteW && rsE == writeregW)
            forwardaE = FWD_W;

        forwardbE = FWD_RF;
        if (rtE != '0 && regwriteM && rtE == writeregM)
            forwardbE = FWD_M;
        else if (rtE != '0 && regwriteW && rtE == writeregW)
            forwardbE = FWD_W;
    end

    // D-stage forwarding of the M result into the branch comparator.
    always_comb begin
        forwardaD = (rsD != '0) && regwriteM && (rsD == writeregM);
        forwardbD = (rtD != '0) && regwriteM && (rtD == writeregM);
    end

    // Hazard detection: load-use, branch-on-ALU, branch-on-load, HI/LO busy.
    always_comb begin
        lu_stall   = memtoregE && regwriteE && (writeregE != '0) &&
                     ((writeregE == rsD) || (writeregE == rtD));
        br_stall   = (branchD || jrD) && regwriteE && (writeregE != '0) &&
                     ((writeregE == rsD) || (writeregE == rtD));
        brld_stall = (branchD || jrD) && memtoregM && (writeregM != '0) &&
                     ((writeregM == rsD) || (writeregM == rtD));
        md_stall   = (hilotoregD || mdstartD) && (md_busy || mdstartE);
        h_stall    = lu_stall || br_stall || brld_stall || md_stall;
    end

    assign mem_stall = imem_stall || dmem_stall;

    // Stage control priority: exception flush, memory freeze, hazard bubble.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        stallW = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (exc_flush) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (mem_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            stallW = 1'b1;
        end else if (h_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    // An MD op held in E by a memory freeze does not start until E moves.
    assign md_start = mdstartE && !stallE;

    md_tracker #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_tracker (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .is_div (divE),
        .abort  (exc_flush),
        .busy   (md_busy),
        .done   (md_done)
    );

endmodule

// File: tb/tb_hazard_sb.sv
// Scoreboard bench for hazard_sb: a cycle-level reference model pushes the
// expected outputs of every cycle; a monitor pops and compares on negedge.
module tb_hazard_sb;

    localparam int REG_AW  = 5;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 34;

    logic clk, rst;
    logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic branchD, jrD, hilotoregD, mdstartD;
    logic regwriteE, memtoregE, mdstartE, divE;
    logic regwriteM, memtoregM, regwriteW;
    logic imem_stall, dmem_stall, exc_flush;
    logic forwardaD, forwardbD;
    logic [1:0] forwardaE, forwardbE;
    logic stallF, stallD, stallE, stallM, stallW;
    logic flushD, flushE, flushM;
    logic md_busy, md_done;

    hazard_sb #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
        .hilotoregD(hilotoregD), .mdstartD(mdstartD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE),
        .mdstartE(mdstartE), .divE(divE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .writeregW(writeregW), .regwriteW(regwriteW),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall), .exc_flush(exc_flush),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .md_busy(md_busy), .md_done(md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] fwd_e;
        logic [1:0] fwd_d;
        logic [4:0] stall;
        logic [2:0] flush;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state in absolute cycle numbers.
    int cyc      = 0;
    int busy_end = -1;
    int done_cyc = -1;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd_e(input int src, input int wm, input bit rwm,
                                             input int ww, input bit rww);
        if (src == 0) return 2'b00;
        if (rwm && src == wm) return 2'b10;
        if (rww && src == ww) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit hits(input int dst, input int a, input int b);
        return dst != 0 && (dst == a || dst == b);
    endfunction

    // Compute this cycle's expected outputs, queue them, then advance the
    // model across the coming clock edge.
    task automatic push_expected();
        exp_t e;
        bit busy_now, hz, br;
        int n;
        busy_now = (cyc <= busy_end);
        br = branchD || jrD;
        e.fwd_e = {ref_fwd_e(rsE, writeregM, regwriteM, writeregW, regwriteW),
                   ref_fwd_e(rtE, writeregM, regwriteM, writeregW, regwriteW)};
        e.fwd_d = {bit'(rsD != 0 && regwriteM && rsD == writeregM),
                   bit'(rtD != 0 && regwriteM && rtD == writeregM)};
        hz = (memtoregE && regwriteE && hits(writeregE, rsD, rtD)) ||
             (br && regwriteE && hits(writeregE, rsD, rtD)) ||
             (br && memtoregM && hits(writeregM, rsD, rtD)) ||
             ((hilotoregD || mdstartD) && (busy_now || mdstartE));
        if (exc_flush) begin
            e.stall = 5'b00000; e.flush = 3'b111;
        end else if (imem_stall || dmem_stall) begin
            e.stall = 5'b11111; e.flush = 3'b000;
        end else if (hz) begin
            e.stall = 5'b11000; e.flush = 3'b010;
        end else begin
            e.stall = 5'b00000; e.flush = 3'b000;
        end
        e.busy = busy_now;
        e.done = (cyc == done_cyc);
        exp_q.push_back(e);

        if (rst || exc_flush) begin
            if (busy_end > cyc) busy_end = cyc;
            done_cyc = -1;
        end else if (mdstartE && !(imem_stall || dmem_stall) && !busy_now) begin
            n = divE ? DIV_LAT : MUL_LAT;
            busy_end = cyc + n;
            done_cyc = cyc + n + 1;
        end
    endtask

    task automatic step();
        push_expected();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        rst = 0;
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        branchD = 0; jrD = 0; hilotoregD = 0; mdstartD = 0;
        regwriteE = 0; memtoregE = 0; mdstartE = 0; divE = 0;
        regwriteM = 0; memtoregM = 0; regwriteW = 0;
        imem_stall = 0; dmem_stall = 0; exc_flush = 0;
    endtask

    task automatic rand_inputs();
        rsD = REG_AW'($urandom_range(0, 3));
        rtD = REG_AW'($urandom_range(0, 3));
        rsE = REG_AW'($urandom_range(0, 3));
        rtE = REG_AW'($urandom_range(0, 3));
        writeregE = REG_AW'($urandom_range(0, 3));
        writeregM = REG_AW'($urandom_range(0, 3));
        writeregW = REG_AW'($urandom_range(0, 3));
        branchD    = ($urandom_range(0, 3) == 0);
        jrD        = ($urandom_range(0, 7) == 0);
        hilotoregD = ($urandom_range(0, 7) == 0);
        mdstartD   = ($urandom_range(0, 7) == 0);
        regwriteE  = $urandom_range(0, 1);
        memtoregE  = $urandom_range(0, 1);
        mdstartE   = ($urandom_range(0, 9) == 0);
        divE       = ($urandom_range(0, 3) == 0);
        regwriteM  = $urandom_range(0, 1);
        memtoregM  = $urandom_range(0, 1);
        regwriteW  = $urandom_range(0, 1);
        imem_stall = ($urandom_range(0, 9) == 0);
        dmem_stall = ($urandom_range(0, 9) == 0);
        exc_flush  = ($urandom_range(0, 39) == 0);
        rst        = ($urandom_range(0, 199) == 0);
    endtask

    // Monitor: every queued cycle is compared while the DUT holds it.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp("fwd_e", {4'b0, forwardaE, forwardbE}, {4'b0, e.fwd_e});
            cmp("fwd_d", {6'b0, forwardaD, forwardbD}, {6'b0, e.fwd_d});
            cmp("stall", {3'b0, stallF, stallD, stallE, stallM, stallW}, {3'b0, e.stall});
            cmp("flush", {5'b0, flushD, flushE, flushM}, {5'b0, e.flush});
            cmp("md_busy", {7'b0, md_busy}, {7'b0, e.busy});
            cmp("md_done", {7'b0, md_done}, {7'b0, e.done});
        end
    end

    int busy_cnt, done_cnt, stall_cnt;

    initial begin
        clear_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        step();
        rst = 0;
        #1;
        cmp("reset_busy", {7'b0, md_busy}, 8'h0);
        cmp("reset_done", {7'b0, md_done}, 8'h0);

        // E forwarding: M wins over W; register 0 never forwards.
        rsE = 5; writeregM = 5; regwriteM = 1; writeregW = 5; regwriteW = 1;
        #1 cmp("fwdaE_m_prio", {6'b0, forwardaE}, 8'h2);
        step();
        rsE = 0;
        #1 cmp("fwdaE_r0", {6'b0, forwardaE}, 8'h0);
        step();
        regwriteM = 0; rtE = 5;
        #1 cmp("fwdbE_w", {6'b0, forwardbE}, 8'h1);
        step();
        clear_inputs();

        // Load-use, then memory freeze over it, then release.
        memtoregE = 1; regwriteE = 1; writeregE = 8; rtD = 8;
        #1 cmp("lu_stall", {5'b0, stallF, stallD, flushE}, 8'h7);
        step();
        dmem_stall = 1;
        #1 cmp("lu_dmem", {2'b0, stallF, stallD, stallE, stallM, stallW, flushE}, 8'h3e);
        step();
        dmem_stall = 0;
        #1 cmp("lu_resume", {5'b0, stallF, stallE, flushE}, 8'h5);
        step();
        writeregE = 0; rtD = 0;
        #1 cmp("lu_r0", {5'b0, stallF, stallD, flushE}, 8'h0);
        step();
        clear_inputs();

        // DIV followed by a waiting MFHI.
        mdstartE = 1; divE = 1;
        step();
        mdstartE = 0; divE = 0; hilotoregD = 1;
        busy_cnt = 0; done_cnt = 0; stall_cnt = 0;
        for (int i = 0; i < DIV_LAT + 4; i++) begin
            #1;
            if (md_busy) busy_cnt++;
            if (md_done) begin
                done_cnt++;
                cmp("mfhi_released", {7'b0, stallD}, 8'h0);
            end
            if (stallF) stall_cnt++;
            step();
        end
        cmp("div_busy_cycles", 8'(busy_cnt), 8'(DIV_LAT));
        cmp("div_done_pulses", 8'(done_cnt), 8'h1);
        cmp("mfhi_stall_cycles", 8'(stall_cnt), 8'(DIV_LAT));
        clear_inputs();

        // Exception at cycle 10 of a DIV abandons it.
        mdstartE = 1; divE = 1;
        step();
        mdstartE = 0; divE = 0;
        repeat (9) step();
        exc_flush = 1;
        #1 cmp("exc_flushes", {5'b0, flushD, flushE, flushM}, 8'h7);
        step();
        exc_flush = 0;
        #1 cmp("exc_busy_cleared", {7'b0, md_busy}, 8'h0);
        done_cnt = 0;
        for (int i = 0; i < DIV_LAT + 2; i++) begin
            if (md_done) done_cnt++;
            step();
        end
        cmp("exc_no_done", 8'(done_cnt), 8'h0);

        // Reset mid-MULT, then a clean MULT.
        mdstartE = 1;
        step();
        mdstartE = 0; rst = 1;
        step();
        rst = 0;
        #1 cmp("rst_busy", {6'b0, md_busy, md_done}, 8'h0);
        mdstartE = 1;
        step();
        mdstartE = 0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < MUL_LAT + 3; i++) begin
            if (md_busy) busy_cnt++;
            if (md_done) done_cnt++;
            step();
        end
        cmp("mul_busy_cycles", 8'(busy_cnt), 8'(MUL_LAT));
        cmp("mul_done_pulses", 8'(done_cnt), 8'h1);

        // Memory freeze holds an MD start in E.
        dmem_stall = 1; mdstartE = 1;
        step();
        dmem_stall = 0; mdstartE = 0;
        #1 cmp("md_start_held", {7'b0, md_busy}, 8'h0);
        step();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end
        clear_inputs();
        step();

        @(posedge clk);
        @(posedge clk);
        cmp("queue_drained", 8'(exp_q.size()), 8'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
